// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave byte engine: FSM encoding, bus constants, bit-count marks.
// The optional master-read path is selected by the I2C_SLAVE_READ_EN macro.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } state_e;

    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

    // Bit-counter marks: value before the 8th rise, during the ACK slot, after the 9th rise.
    localparam logic [3:0] LAST_BIT_CNT  = 4'd7;
    localparam logic [3:0] ACK_SLOT_CNT  = 4'd8;
    localparam logic [3:0] ACK_CLOCK_CNT = 4'd9;

`ifdef I2C_SLAVE_READ_EN
    localparam logic READ_ENABLED = 1'b1;
`else
    localparam logic READ_ENABLED = 1'b0;
`endif

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronizes raw SCL/SDA into clk and derives SCL edges plus START/STOP bus conditions.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2  // at least 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic sda_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;

    // NOTE: synchronizers reset to 1 (idle bus) so reset release never looks like a bus edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// Byte-level I2C slave: address match, write-byte reception with ACK, optional master read.
// Define I2C_SLAVE_READ_EN to add tx_data/tx_req and accept R/W=1 addresses.
module i2c_slave_byte_engine
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
`ifdef I2C_SLAVE_READ_EN
    input  logic [7:0] tx_data,
    output logic       tx_req,
`endif
    output logic       sda_oe,
    output logic       start_det,
    output logic       stop_det,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       busy
);

    logic scl_rise, scl_fall, sda_s, start_ev, stop_ev;

    i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_bus_cond (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .sda_o      (sda_s),
        .start_o    (start_ev),
        .stop_o     (stop_ev)
    );

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       first_pend_q, first_pend_d;
    logic       addr_hit;
`ifdef I2C_SLAVE_READ_EN
    logic       rw_q, rw_d;
    logic       tx_req_q, tx_req_d;
    logic [7:0] tx_shift_q, tx_shift_d;
`endif

    assign addr_hit = (shift_q[6:0] == DEV_ADDR) && (shift_q[6:0] != GEN_CALL_ADDR)
                    && ((sda_s == 1'b0) || READ_ENABLED);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        rx_valid_d   = 1'b0;
        rx_first_d   = 1'b0;
        first_pend_d = first_pend_q;
`ifdef I2C_SLAVE_READ_EN
        rw_d         = rw_q;
        tx_req_d     = 1'b0;
        tx_shift_d   = tx_shift_q;
`endif
        if (start_ev) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_ev) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT_CNT) begin
                        if (addr_hit) begin
                            state_d      = ST_ADDR_ACK;
                            first_pend_d = 1'b1;
`ifdef I2C_SLAVE_READ_EN
                            rw_d         = sda_s;
`endif
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK, ST_WRITE_ACK: begin
                    if (scl_fall && bit_cnt_q == ACK_SLOT_CNT) begin
                        sda_oe_d = ~I2C_ACK;
                    end else if (scl_rise) begin
                        bit_cnt_d = ACK_CLOCK_CNT;
`ifdef I2C_SLAVE_READ_EN
                        if (state_q == ST_ADDR_ACK && rw_q) tx_req_d = 1'b1;
`endif
                    end else if (scl_fall && bit_cnt_q == ACK_CLOCK_CNT) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        state_d   = ST_WRITE;
`ifdef I2C_SLAVE_READ_EN
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d    = ST_READ;
                            sda_oe_d   = ~tx_data[7];
                            tx_shift_d = {tx_data[6:0], 1'b0};
                        end
`endif
                    end
                end
                ST_WRITE: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT_CNT) begin
                        rx_data_d    = {shift_q[6:0], sda_s};
                        rx_valid_d   = 1'b1;
                        rx_first_d   = first_pend_q;
                        first_pend_d = 1'b0;
                        state_d      = ST_WRITE_ACK;
                    end
                end
`ifdef I2C_SLAVE_READ_EN
                ST_READ: begin
                    if (scl_fall) begin
                        sda_oe_d   = ~tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_BIT_CNT) state_d = ST_READ_ACK;
                    end
                end
                ST_READ_ACK: begin
                    if (scl_fall && bit_cnt_q == ACK_SLOT_CNT) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        bit_cnt_d = ACK_CLOCK_CNT;
                        if (sda_s == I2C_NACK) state_d = ST_IGNORE;
                        else                   tx_req_d = 1'b1;
                    end else if (scl_fall && bit_cnt_q == ACK_CLOCK_CNT) begin
                        bit_cnt_d  = '0;
                        state_d    = ST_READ;
                        sda_oe_d   = ~tx_data[7];
                        tx_shift_d = {tx_data[6:0], 1'b0};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            first_pend_q <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            rw_q         <= 1'b0;
            tx_req_q     <= 1'b0;
            tx_shift_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            first_pend_q <= first_pend_d;
`ifdef I2C_SLAVE_READ_EN
            rw_q         <= rw_d;
            tx_req_q     <= tx_req_d;
            tx_shift_q   <= tx_shift_d;
`endif
        end
    end

    assign sda_oe    = sda_oe_q;
    assign start_det = start_ev;
    assign stop_det  = stop_ev;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_IGNORE);
`ifdef I2C_SLAVE_READ_EN
    assign tx_req    = tx_req_q;
`endif

endmodule
